// File: rtl/digitron_pkg.sv
// Shared constants for the scanned 7-segment display: segment patterns,
// the Mode encoding and the BCD width helper used by the converter.
package digitron_pkg;

    typedef enum logic {
        MODE_HEX = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    // Active-high patterns, bit6..0 = g..a
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

    // BCD digits the converter keeps: enough for any DATA_W-bit value
    // (ceil(dw/3) over-covers log10(2)*dw) and always at least one digit
    // beyond the display so overflow has somewhere to land.
    function automatic int bcd_width(input int dw, input int nd);
        int d;
        d = (dw + 2) / 3;
        return (d > nd) ? d : nd + 1;
    endfunction

endpackage

// File: rtl/digitron_bin2bcd.sv
// Sequential double-dabble converter: one shift per cycle after Start,
// Done pulses for one cycle after the last shift with Digits/Overflow valid.
module digitron_bin2bcd
    import digitron_pkg::*;
#(
    parameter int DATA_W     = 20,
    parameter int NUM_DIGITS = 6,
    parameter int BCD_D      = 7
) (
    input  logic                         CLK,
    input  logic                         RSTn,
    input  logic                         Start,
    input  logic [DATA_W-1:0]            Bin,
    output logic                         Done,
    output logic [NUM_DIGITS-1:0][3:0]   Digits,
    output logic                         Overflow
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]  sr;
    logic [BCD_D*4-1:0] bcd;
    logic [BCD_D*4-1:0] adj;
    logic [CW-1:0]      cnt;
    logic               busy;

    // Add-3 correction on every BCD digit that would reach 10 after the shift
    always_comb begin
        adj = bcd;
        for (int d = 0; d < BCD_D; d++) begin
            if (bcd[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
    end

    // Shift engine: load on Start, DATA_W shifts, then a single Done pulse
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sr   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            Done <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Start) begin
                sr   <= Bin;
                bcd  <= '0;
                cnt  <= CW'(DATA_W);
                busy <= 1'b1;
            end else if (busy) begin
                bcd <= {adj[BCD_D*4-2:0], sr[DATA_W-1]};
                sr  <= sr << 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    Done <= 1'b1;
                end
            end
        end
    end

    assign Digits   = bcd[NUM_DIGITS*4-1:0];
    assign Overflow = |bcd[BCD_D*4-1:NUM_DIGITS*4];

endmodule

// File: rtl/digitron_scan_display.sv
// Multiplexed 7-segment driver: load handshake, hex or decimal conversion
// into a double-buffered digit store, and a free-running digit scan.
module digitron_scan_display
    import digitron_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int DATA_W         = 20,
    parameter int SCAN_DIV       = 200,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int CS_ACTIVE_LOW  = 1
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  Load,
    output logic                  Ready,
    input  logic [DATA_W-1:0]     Data,
    input  logic                  Mode,
    input  logic                  Blank_En,
    input  logic [NUM_DIGITS-1:0] Dp,
    output logic                  Overflow,
    output logic [7:0]            Digitron_Out,
    output logic [NUM_DIGITS-1:0] DigitronCS_Out
);

    localparam int BCD_D = bcd_width(DATA_W, NUM_DIGITS);
    localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW    = DATA_W + 4 * NUM_DIGITS;

    // XOR masks that turn active-high internal values into pin polarity
    localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW != 0}};
    localparam logic [NUM_DIGITS-1:0] CS_OFF  = {NUM_DIGITS{CS_ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEX,
        ST_DEC
    } st_e;

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic                  blank;
        logic [NUM_DIGITS-1:0] dp;
    } ld_req_t;

    st_e                          st;
    ld_req_t                      req_in, req_q;
    logic                         accept, cv_start, cv_done, cv_ovf;
    logic [NUM_DIGITS-1:0][3:0]   cv_dig, hex_dig, src_dig;
    logic [HW-1:0]                hex_ext;
    logic                         hex_ovf, src_ovf, zero_above;
    logic [NUM_DIGITS-1:0]        src_blank;

    // Display buffer: only ever written at commit
    logic [NUM_DIGITS-1:0][3:0]   buf_dig;
    logic [NUM_DIGITS-1:0]        buf_dp, buf_blank;

    // Scan state
    logic [SW-1:0]                scan_cnt;
    logic [IW-1:0]                idx;
    logic                         wrap;
    logic [7:0]                   cur_seg;
    logic [NUM_DIGITS-1:0]        cur_cs;

    assign req_in   = '{data: Data, blank: Blank_En, dp: Dp};
    assign accept   = Load & Ready;
    // Converter grabs Data straight off the port so its first shift lands on k+1
    assign cv_start = accept & (mode_e'(Mode) == MODE_DEC);

    digitron_bin2bcd #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS),
        .BCD_D      (BCD_D)
    ) u_bin2bcd (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .Start    (cv_start),
        .Bin      (Data),
        .Done     (cv_done),
        .Digits   (cv_dig),
        .Overflow (cv_ovf)
    );

    // Hex digits are raw nibbles; anything above the displayed nibbles overflows
    assign hex_ext = {{(4*NUM_DIGITS){1'b0}}, req_q.data};
    assign hex_dig = hex_ext[4*NUM_DIGITS-1:0];
    assign hex_ovf = |hex_ext[HW-1:4*NUM_DIGITS];

    // Commit source and leading-zero mask; digit 0 is never blanked
    always_comb begin
        src_dig    = (st == ST_DEC) ? cv_dig : hex_dig;
        src_ovf    = (st == ST_DEC) ? cv_ovf : hex_ovf;
        src_blank  = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above   = zero_above & (src_dig[i] == 4'd0);
            src_blank[i] = req_q.blank & zero_above;
        end
    end

    // Load handshake FSM: capture, wait for conversion, commit the buffer
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            st        <= ST_IDLE;
            Ready     <= 1'b1;
            Overflow  <= 1'b0;
            req_q     <= '0;
            buf_dig   <= '0;
            buf_dp    <= '0;
            buf_blank <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (accept) begin
                        req_q <= req_in;
                        Ready <= 1'b0;
                        st    <= (mode_e'(Mode) == MODE_DEC) ? ST_DEC : ST_HEX;
                    end
                end
                ST_HEX, ST_DEC: begin
                    if (st == ST_HEX || cv_done) begin
                        buf_dig   <= src_dig;
                        buf_dp    <= req_q.dp;
                        buf_blank <= src_blank;
                        Overflow  <= src_ovf;
                        Ready     <= 1'b1;
                        st        <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign wrap = (scan_cnt == SW'(SCAN_DIV - 1));

    // Pattern for the digit about to be shown, read from the committed buffer
    always_comb begin
        cur_cs      = '0;
        cur_cs[idx] = 1'b1;
        cur_seg[7]  = buf_dp[idx];
        if (Overflow)
            cur_seg[6:0] = SEG_DASH;
        else if (buf_blank[idx])
            cur_seg[6:0] = SEG_BLANK;
        else
            cur_seg[6:0] = seg_of(buf_dig[idx]);
    end

    // Free-running scan: outputs update only on a dwell wrap, idx points at the next digit
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            scan_cnt       <= '0;
            idx            <= '0;
            Digitron_Out   <= SEG_OFF;
            DigitronCS_Out <= CS_OFF;
        end else begin
            if (wrap) begin
                scan_cnt       <= '0;
                idx            <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
                Digitron_Out   <= cur_seg ^ SEG_OFF;
                DigitronCS_Out <= cur_cs ^ CS_OFF;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_digitron_scan_display.sv
// Bench for digitron_scan_display: directed scenarios plus random loads,
// each frame compared against an arithmetic model of the displayed value.
module tb_digitron_scan_display;

    localparam int N  = 6;
    localparam int DW = 20;
    localparam int SD = 4;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          Load = 1'b0;
    logic          Mode = 1'b0;
    logic          Blank_En = 1'b0;
    logic [DW-1:0] Data = '0;
    logic [N-1:0]  Dp = '0;
    logic          Ready, Overflow;
    logic [7:0]    Digitron_Out;
    logic [N-1:0]  DigitronCS_Out;

    digitron_scan_display #(
        .NUM_DIGITS(N), .DATA_W(DW), .SCAN_DIV(SD),
        .SEG_ACTIVE_LOW(1), .CS_ACTIVE_LOW(1)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .Load(Load), .Ready(Ready), .Data(Data),
        .Mode(Mode), .Blank_En(Blank_En), .Dp(Dp), .Overflow(Overflow),
        .Digitron_Out(Digitron_Out), .DigitronCS_Out(DigitronCS_Out)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: the value currently expected on the display
    longint      m_val = 0;
    bit          m_mode = 1'b0;
    bit          m_blank = 1'b0;
    bit [N-1:0]  m_dp = '0;

    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic longint pw(input longint b, input int e);
        longint r = 1;
        for (int k = 0; k < e; k++) r = r * b;
        return r;
    endfunction

    function automatic bit exp_ovf();
        return m_val >= pw(m_mode ? 10 : 16, N);
    endfunction

    // Pin value (active low) for digit i of the modelled value
    function automatic logic [7:0] exp_seg(input int i);
        longint     b = m_mode ? 10 : 16;
        logic [6:0] g;
        if (exp_ovf())
            g = 7'h40;
        else if (m_blank && i > 0 && m_val < pw(b, i))
            g = 7'h00;
        else
            g = pat[int'((m_val / pw(b, i)) % b)];
        return ~{m_dp[i], g};
    endfunction

    task automatic model_clear();
        m_val = 0; m_mode = 0; m_blank = 0; m_dp = '0;
    endtask

    // Present a load, then count busy cycles while hammering Load with junk.
    // abort_at > 0 returns early after that many busy cycles without a commit.
    task automatic load(input logic [DW-1:0] d, input bit md, input bit bl,
                        input logic [N-1:0] dp, input int abort_at, output int busy);
        @(negedge CLK);
        Data = d; Mode = md; Blank_En = bl; Dp = dp; Load = 1'b1;
        @(posedge CLK); #1;
        Load = 1'b0;
        chk("ready_drop", Ready, 1'b0);
        busy = 1;
        while (!Ready && busy < 100) begin
            if (abort_at > 0 && busy == abort_at) break;
            Load = 1'($urandom); Data = DW'($urandom); Mode = 1'($urandom);
            Blank_En = 1'($urandom); Dp = N'($urandom);
            @(posedge CLK); #1;
            if (!Ready) busy++;
        end
        Load = 1'b0;
        if (abort_at == 0) begin
            m_val = longint'(d); m_mode = md; m_blank = bl; m_dp = dp;
        end
    endtask

    // Watch N consecutive scan wraps and compare each digit to the model
    task automatic check_frame();
        logic [N-1:0] prev;
        int cyc, idx, last_idx;
        prev = DigitronCS_Out;
        last_idx = 0;
        for (int w = 0; w < N; w++) begin
            cyc = 0;
            do begin
                @(posedge CLK); #1;
                cyc++;
            end while (DigitronCS_Out == prev && cyc < 3 * SD);
            chk("wrap_seen", 32'(DigitronCS_Out != prev), 1);
            prev = DigitronCS_Out;
            if (w > 0) chk("dwell", cyc, SD);
            chk("cs_onehot", 32'($onehot(~DigitronCS_Out)), 1);
            idx = 0;
            for (int k = 0; k < N; k++) if (!DigitronCS_Out[k]) idx = k;
            if (w > 0) chk("scan_order", idx, (last_idx + 1) % N);
            chk($sformatf("seg%0d", idx), Digitron_Out, exp_seg(idx));
            last_idx = idx;
        end
        chk("overflow", Overflow, exp_ovf());
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", Ready, 1'b1);
        chk("rst_ovf", Overflow, 1'b0);
        chk("rst_seg", Digitron_Out, 8'hFF);
        chk("rst_cs", DigitronCS_Out, {N{1'b1}});
    endtask

    // Release reset and check the first wrap lands on edge SD showing digit 0 = "0"
    task automatic release_reset();
        @(negedge CLK);
        RSTn = 1'b1;
        model_clear();
        for (int e = 1; e <= SD; e++) begin
            @(posedge CLK); #1;
            if (e == SD - 1) chk("pre_wrap_cs", DigitronCS_Out, {N{1'b1}});
        end
        chk("first_cs", DigitronCS_Out, 6'b111110);
        chk("first_seg", Digitron_Out, 8'hC0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int cat;
        logic [DW-1:0] d;
        bit md, bl;

        RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk_reset_outputs();
        release_reset();
        check_frame();

        load(20'hABCDE, 0, 0, '0, 0, busy);
        chk("busy_hex", busy, 1);
        check_frame();

        load(20'd123456, 0, 0, '0, 0, busy);
        chk("busy_hex2", busy, 1);
        check_frame();
        load(20'd123456, 1, 0, '0, 0, busy);
        chk("busy_dec", busy, DW + 1);
        check_frame();

        load(20'd1000000, 1, 0, '0, 0, busy);
        check_frame();
        load(20'd999999, 1, 0, '0, 0, busy);
        check_frame();

        load(20'd42, 1, 1, 6'b000001, 0, busy);
        check_frame();
        load(20'd0, 1, 1, '0, 0, busy);
        check_frame();

        for (int r = 0; r < 12; r++) begin
            cat = $urandom_range(0, 3);
            case (cat)
                0:       d = DW'($urandom);
                1:       d = DW'($urandom_range(0, 999));
                2:       d = DW'($urandom_range(999990, 1000010));
                default: d = '0;
            endcase
            md = 1'($urandom);
            bl = 1'($urandom);
            load(d, md, bl, N'($urandom), 0, busy);
            chk("busy_rand", busy, md ? DW + 1 : 1);
            check_frame();
        end

        // Abort a decimal conversion partway through
        load(20'd654321, 1, 1, 6'b101010, 10, busy);
        chk("abort_busy", busy, 10);
        RSTn = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge CLK);
        #1;
        chk_reset_outputs();
        release_reset();
        check_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
